// File: rtl/up_down_counter_checker.sv
// -----------------------------------------------------------------------------
// up_down_counter_checker
//
// In-line monitor for an 8-bit load/up/down counter. It keeps its own reference
// model of the counter, driven by the same control inputs. Each edge it compares
// the observed count with the model. It reports a registered mismatch pulse, a
// sticky fail flag, a saturating error count, and the model and observed values
// captured at the first mismatch.
//
// Optional feature macro: CHK_WRAP_FLAG_EN
//   Defining it adds the wrap_up / wrap_dn pulse outputs.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset (shared with the counter)
//   chk_en     in   checking enable; 0 suspends compares, model still tracks
//   load       in   counter load strobe (priority over updown)
//   updown     in   counter direction, 1 = increment, 0 = decrement
//   data_in    in   counter load value
//   count      in   observed counter output
//   expected   out  reference-model value
//   mismatch   out  one-cycle registered pulse on a failed compare
//   fail       out  sticky flag, set on the first mismatch
//   err_cnt    out  saturating mismatch count
//   first_exp  out  model value captured at the first mismatch
//   first_obs  out  observed count captured at the first mismatch
//   wrap_up    out  (CHK_WRAP_FLAG_EN) pulse when the model goes max -> 0
//   wrap_dn    out  (CHK_WRAP_FLAG_EN) pulse when the model goes 0 -> max
// -----------------------------------------------------------------------------
module up_down_counter_checker #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chk_en,
    input  logic             load,
    input  logic             updown,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] expected,
    output logic             mismatch,
    output logic             fail,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_obs
`ifdef CHK_WRAP_FLAG_EN
    ,
    output logic             wrap_up,
    output logic             wrap_dn
`endif
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        CHECK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic   compare_en;
    logic   differ;

    // Both operands are pre-edge values: count reflects the counter's last
    // edge and expected reflects the model's last edge, so no alignment delay.
    assign differ = (count != expected);

    // FSM state register.
    // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SYNC;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A compare happens only in CHECK with chk_en high.
    // SYNC skips the first edge after reset release. Returning from HOLD also
    // spends one edge without a compare.
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        next_state = state;
        compare_en = 1'b0;
        case (state)
            SYNC: begin
                next_state = CHECK;
            end
            CHECK: begin
                if (chk_en) begin
                    compare_en = 1'b1;
                end else begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (chk_en) begin
                    next_state = CHECK;
                end
            end
            default: begin
                next_state = SYNC;
            end
        endcase
    end

    // Reference model: tracks on every edge regardless of chk_en or state.
    // Wraps modulo 2^WIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            expected <= '0;
        end else if (load) begin
            expected <= data_in;
        end else if (updown) begin
            expected <= expected + 1'b1;
        end else begin
            expected <= expected - 1'b1;
        end
    end

    // Compare results and error statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch  <= 1'b0;
            fail      <= 1'b0;
            err_cnt   <= '0;
            first_exp <= '0;
            first_obs <= '0;
        end else begin
            mismatch <= compare_en && differ;
            if (compare_en && differ) begin
                // Saturate: hold at all-ones instead of wrapping.
                if (err_cnt != {ERR_W{1'b1}}) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                // Only the first failure is captured. Later ones leave the
                // snapshot alone until reset.
                if (!fail) begin
                    fail      <= 1'b1;
                    first_exp <= expected;
                    first_obs <= count;
                end
            end
        end
    end

`ifdef CHK_WRAP_FLAG_EN
    // Wrap pulses come from model counting steps only. A load never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_up <= 1'b0;
            wrap_dn <= 1'b0;
        end else begin
            wrap_up <= !load &&  updown && (expected == {WIDTH{1'b1}});
            wrap_dn <= !load && !updown && (expected == '0);
        end
    end
`endif

endmodule

// File: doc/up_down_counter_checker.md
Name: up_down_counter_checker

Overview:
- Synthesizable in-line monitor that observes the control inputs and `count` output of the 8-bit load/up/down counter.
- Holds its own reference model of the counter and flags every cycle where the observed count differs from the model.
- Sits beside the counter in simulation or on FPGA and drives pass/fail indicators plus error statistics.

Parameters:
- WIDTH, 8, width of data_in, count and the reference model.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- chk_en  input  1  checking enable; 0 freezes comparison, the model still tracks.
- load  input  1  counter load strobe, same signal as driven into the counter.
- updown  input  1  counter direction; 1 = increment, 0 = decrement.
- data_in  input  WIDTH  counter load value.
- count  input  WIDTH  observed counter output.
- expected  output  WIDTH  current reference-model value.
- mismatch  output  1  one-cycle registered pulse when a compare fails.
- fail  output  1  sticky flag, set on the first mismatch.
- err_cnt  output  ERR_W  saturating count of mismatches.
- first_exp  output  WIDTH  model value captured at the first mismatch.
- first_obs  output  WIDTH  observed count captured at the first mismatch.

Behaviour:
- Reset (async, rst=1):
  - expected=0, mismatch=0, fail=0, err_cnt=0, first_exp=0, first_obs=0.
  - FSM enters SYNC.
  - Counter reset is the same `rst` signal, so the model and the counter clear together.
- Model update, every rising edge with rst=0, regardless of chk_en:
  - load=1: expected <= data_in. Load has priority over updown.
  - load=0, updown=1: expected <= expected+1, modulo 2^WIDTH (255 -> 0).
  - load=0, updown=0: expected <= expected-1, modulo 2^WIDTH (0 -> 255).
- Compare:
  - At each rising edge, the pre-edge `count` is compared with the pre-edge `expected`. Both reflect the previous edge, so there is zero added latency.
  - Mismatch is reported on the `mismatch` output one cycle later (registered).
- FSM states:
  - SYNC: entered after reset. The first edge with rst=0 performs no compare, to avoid the reset-release race. Goes to CHECK on the next edge.
  - CHECK:
    - If chk_en=1 and count!=expected: mismatch<=1; err_cnt<=err_cnt+1, saturating at 2^ERR_W-1.
    - If fail=0 at that compare: first_exp<=expected, first_obs<=count, fail<=1.
    - Stays in CHECK.
  - HOLD: entered from CHECK when chk_en=0. No compares; mismatch<=0. Returns to CHECK on the edge after chk_en returns to 1. The model keeps tracking throughout.
- Further behaviour of outputs after the first mismatch:
  - fail stays set until rst.
  - first_exp and first_obs never update again until rst.
  - err_cnt keeps counting; saturation holds the value with no wrap.
- Mismatch de-asserts on the edge following any passing or skipped compare.
- rst asserted mid-run clears everything immediately (async); the model restarts at 0.

Optional Feature:
- Macro: CHK_WRAP_FLAG_EN.
- Defined: adds outputs `wrap_up` (1 bit) and `wrap_dn` (1 bit).
  - Registered one-cycle pulses when the model goes from max to 0 on an increment, or from 0 to max on a decrement.
  - A load never raises either flag.
  - Both reset to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Clean run:
  - Stimulus: rst pulse; updown=1 for 10 cycles; load 200; updown=0 for 20 cycles; load 100. Counter model is correct.
  - Required: mismatch never 1, fail=0, err_cnt=0, expected tracks 200 -> 180 and then 100.
- Injected fault:
  - Stimulus: after load 50 with updown=1, force count to 60 for one cycle.
  - Required: mismatch pulses once; fail=1; err_cnt=1; first_exp=51 (or the matching model value at that edge), first_obs=60. A second forced error gives err_cnt=2 while first_* stay unchanged.
- Wrap-around:
  - Stimulus: load 254, updown=1 for 3 cycles; then load 1, updown=0 for 3 cycles.
  - Required: expected goes 254, 255, 0, 1 and then 1, 0, 255, 254, with no false mismatch.
  - With CHK_WRAP_FLAG_EN: wrap_up pulses once and wrap_dn pulses once.
- Enable gating:
  - Stimulus: chk_en=0 while count is forced wrong for 5 cycles; release the force and set chk_en=1.
  - Required: err_cnt unchanged, mismatch=0, and the model is still aligned after re-enable.
- Saturation and reset:
  - Stimulus: with ERR_W=2, inject 6 mismatches.
  - Required: err_cnt holds at 3.
  - Then assert rst mid-cycle: all outputs are 0 immediately, and the first compare after release is skipped.
